// File: rtl/tx_pkt_arbiter_pkg.sv
// Shared types and constants for the TX packet arbiter.
// Build option: TX_ARB_PRIO_EN (channel 0 strict priority, see rr_select).
package tx_pkt_arbiter_pkg;

  localparam int TUSER_W = 4;

  typedef enum logic [1:0] {
    ARB  = 2'b01,
    XFER = 2'b10
  } arb_state_e;

  // Grant index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_pkt_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
// Build option: TX_ARB_PRIO_EN gives channel 0 strict priority over the rotation.
module rr_select #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [NUM_CH-1:0] w_rr_req;

`ifdef TX_ARB_PRIO_EN
  // Channel 0 is handled outside the rotation, so the ring only sees 1..NUM_CH-1.
  assign w_rr_req = {req[NUM_CH-1:1], 1'b0};
`else
  assign w_rr_req = req;
`endif

  always_comb begin
    int k;
    k       = 0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      k = (int'(last) + i) % NUM_CH;
      if (!gnt_vld && w_rr_req[k[IDX_W-1:0]]) begin
        gnt_idx = k[IDX_W-1:0];
        gnt_vld = 1'b1;
      end
    end
`ifdef TX_ARB_PRIO_EN
    if (req[0]) begin
      gnt_idx = '0;
      gnt_vld = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Merges NUM_CH AXI-stream transport channels into one router stream, packet-atomic.
// Build option: TX_ARB_PRIO_EN (channel 0 wins every arbitration it requests).
//
//   state | meaning
//   ARB   | no owner; outputs quiet, pick next channel by round-robin
//   XFER  | granted channel owns the router until its tlast handshake
module tx_pkt_arbiter
  import tx_pkt_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  localparam int IDX_W     = idx_width(NUM_CH)
) (
  input  logic                           user_clk,
  input  logic                           reset_n,
  input  logic [NUM_CH*DATA_WIDTH*8-1:0] axi_str_tdata_from_trans,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   axi_str_tkeep_from_trans,
  input  logic [NUM_CH*TUSER_W-1:0]      axi_str_tuser_from_trans,
  input  logic [NUM_CH-1:0]              axi_str_tvalid_from_trans,
  input  logic [NUM_CH-1:0]              axi_str_tlast_from_trans,
  output logic [NUM_CH-1:0]              axi_str_tready_to_trans,
  output logic [DATA_WIDTH*8-1:0]        axi_str_tdata_to_router,
  output logic [DATA_WIDTH-1:0]          axi_str_tkeep_to_router,
  output logic [TUSER_W-1:0]             axi_str_tuser_to_router,
  output logic                           axi_str_tvalid_to_router,
  output logic                           axi_str_tlast_to_router,
  input  logic                           axi_str_tready_from_router,
  output logic [IDX_W-1:0]               tx_grant_ch,
  output logic                           tx_busy
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [IDX_W-1:0] w_last_nxt;
  logic [IDX_W-1:0] w_rr_idx;
  logic             w_rr_vld;

  logic [DATA_WIDTH*8-1:0] w_ch_tdata [NUM_CH];
  logic [DATA_WIDTH-1:0]   w_ch_tkeep [NUM_CH];
  logic [TUSER_W-1:0]      w_ch_tuser [NUM_CH];

  logic [DATA_WIDTH*8-1:0] w_sel_tdata;
  logic [DATA_WIDTH-1:0]   w_sel_tkeep;
  logic [TUSER_W-1:0]      w_sel_tuser;
  logic                    w_sel_tvalid;
  logic                    w_sel_tlast;
  logic                    w_beat_done;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign w_ch_tdata[c] = axi_str_tdata_from_trans[c*DATA_WIDTH*8 +: DATA_WIDTH*8];
    assign w_ch_tkeep[c] = axi_str_tkeep_from_trans[c*DATA_WIDTH +: DATA_WIDTH];
    assign w_ch_tuser[c] = axi_str_tuser_from_trans[c*TUSER_W +: TUSER_W];
  end

  assign w_sel_tdata  = w_ch_tdata[r_grant];
  assign w_sel_tkeep  = w_ch_tkeep[r_grant];
  assign w_sel_tuser  = w_ch_tuser[r_grant];
  assign w_sel_tvalid = axi_str_tvalid_from_trans[r_grant];
  assign w_sel_tlast  = axi_str_tlast_from_trans[r_grant];
  assign w_beat_done  = w_sel_tvalid & axi_str_tready_from_router & w_sel_tlast;

  rr_select #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_select (
    .req     (axi_str_tvalid_from_trans),
    .last    (r_last_grant),
    .gnt_idx (w_rr_idx),
    .gnt_vld (w_rr_vld)
  );

  // last_grant resets to the top channel so the first rotation starts at 0.
  always_ff @(posedge user_clk) begin
    if (!reset_n) begin
      r_state      <= ARB;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_CH - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  // Outputs are qualified by reset_n so nothing leaks while reset is held mid-packet.
  always_comb begin
    w_state_nxt              = r_state;
    w_grant_nxt              = r_grant;
    w_last_nxt               = r_last_grant;
    axi_str_tready_to_trans  = '0;
    axi_str_tdata_to_router  = '0;
    axi_str_tkeep_to_router  = '0;
    axi_str_tuser_to_router  = '0;
    axi_str_tvalid_to_router = 1'b0;
    axi_str_tlast_to_router  = 1'b0;
    tx_busy                  = 1'b0;
    tx_grant_ch              = '0;

    case (r_state)
      ARB: begin
        if (w_rr_vld) begin
          w_grant_nxt = w_rr_idx;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (reset_n) begin
          axi_str_tdata_to_router  = w_sel_tdata;
          axi_str_tkeep_to_router  = w_sel_tkeep;
          axi_str_tuser_to_router  = w_sel_tuser;
          axi_str_tvalid_to_router = w_sel_tvalid;
          axi_str_tlast_to_router  = w_sel_tlast;
          for (int c = 0; c < NUM_CH; c++) begin
            axi_str_tready_to_trans[c] = (IDX_W'(c) == r_grant) & axi_str_tready_from_router;
          end
          tx_busy = 1'b1;
        end
        if (w_beat_done) begin
          w_last_nxt  = r_grant;
          w_state_nxt = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase

    if (reset_n) begin
      tx_grant_ch = r_grant;
    end
  end

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Directed-vector bench for tx_pkt_arbiter: per-cycle expectation tables driven
// against simple upstream packet sources; honours TX_ARB_PRIO_EN for grant order.
module tb_tx_pkt_arbiter;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int IW = 2;

  logic                 user_clk = 1'b0;
  logic                 reset_n  = 1'b0;
  logic [NC*DW*8-1:0]   tdata_from = '0;
  logic [NC*DW-1:0]     tkeep_from = '0;
  logic [NC*4-1:0]      tuser_from = '0;
  logic [NC-1:0]        tvalid_from = '0;
  logic [NC-1:0]        tlast_from = '0;
  logic [NC-1:0]        tready_to_trans;
  logic [DW*8-1:0]      tdata_to_router;
  logic [DW-1:0]        tkeep_to_router;
  logic [3:0]           tuser_to_router;
  logic                 tvalid_to_router;
  logic                 tlast_to_router;
  logic                 tready_from_router = 1'b0;
  logic [IW-1:0]        tx_grant_ch;
  logic                 tx_busy;

  int n_vec = 0;
  int n_err = 0;

  int s_len  [NC];
  int s_beat [NC];
  int s_pkts [NC];
  logic [NC-1:0] hold = '0;

  typedef struct {
    logic [NC-1:0] hold;
    logic          rdy;
    logic          busy;
    logic          vld;
    logic          last;
    int            g;
    int            b;
  } cyc_t;

  cyc_t tbl[$];

  tx_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .user_clk                   (user_clk),
    .reset_n                    (reset_n),
    .axi_str_tdata_from_trans   (tdata_from),
    .axi_str_tkeep_from_trans   (tkeep_from),
    .axi_str_tuser_from_trans   (tuser_from),
    .axi_str_tvalid_from_trans  (tvalid_from),
    .axi_str_tlast_from_trans   (tlast_from),
    .axi_str_tready_to_trans    (tready_to_trans),
    .axi_str_tdata_to_router    (tdata_to_router),
    .axi_str_tkeep_to_router    (tkeep_to_router),
    .axi_str_tuser_to_router    (tuser_to_router),
    .axi_str_tvalid_to_router   (tvalid_to_router),
    .axi_str_tlast_to_router    (tlast_to_router),
    .axi_str_tready_from_router (tready_from_router),
    .tx_grant_ch                (tx_grant_ch),
    .tx_busy                    (tx_busy)
  );

  always #5 user_clk = ~user_clk;

  function automatic logic [DW*8-1:0] data_of(input int c, input int b);
    return {16{c[3:0], b[3:0]}};
  endfunction

  function automatic logic [DW-1:0] keep_of(input int c);
    return 16'hFFFF >> c;
  endfunction

  function automatic logic [3:0] user_of(input int c);
    return 4'(c * 3 + 5);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int c = 0; c < NC; c++) begin
      tvalid_from[c] = (s_pkts[c] > 0) && !hold[c];
      tlast_from[c]  = (s_beat[c] == s_len[c] - 1);
      tdata_from[c*DW*8 +: DW*8] = data_of(c, s_beat[c]);
      tkeep_from[c*DW +: DW]     = keep_of(c);
      tuser_from[c*4 +: 4]       = user_of(c);
    end
  endtask

  task automatic clear_srcs();
    hold = '0;
    for (int c = 0; c < NC; c++) begin
      s_len[c]  = 0;
      s_beat[c] = 0;
      s_pkts[c] = 0;
    end
  endtask

  task automatic load(input int c, input int len, input int pkts);
    s_len[c]  = len;
    s_beat[c] = 0;
    s_pkts[c] = pkts;
  endtask

  task automatic cy(input logic [NC-1:0] h, input logic r, input logic bz,
                    input logic v, input logic l, input int g, input int b);
    cyc_t e;
    e.hold = h; e.rdy = r; e.busy = bz; e.vld = v; e.last = l; e.g = g; e.b = b;
    tbl.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},   tx_busy, 0);
    chk({tag, ".tvalid"}, tvalid_to_router, 0);
    chk({tag, ".tready"}, tready_to_trans, 0);
    chk({tag, ".tlast"},  tlast_to_router, 0);
    chk({tag, ".tdata"},  tdata_to_router, 0);
    chk({tag, ".tkeep"},  tkeep_to_router, 0);
    chk({tag, ".tuser"},  tuser_to_router, 0);
    chk({tag, ".grant"},  tx_grant_ch, 0);
  endtask

  // Reset is held across one edge while the sources keep driving whatever they had.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    drive_srcs();
    #2;
    check_idle({tag, "_in"});
    @(posedge user_clk);
    #1;
    reset_n = 1'b1;
    clear_srcs();
    drive_srcs();
    #1;
    check_idle({tag, "_out"});
  endtask

  task automatic run_tbl(input string tag, input int exp_hs);
    cyc_t e;
    int hs;
    logic [NC-1:0] ch_hs;
    logic [NC-1:0] exp_rdy;
    hs = 0;
    foreach (tbl[i]) begin
      e = tbl[i];
      hold = e.hold;
      tready_from_router = e.rdy;
      drive_srcs();
      #2;
      chk($sformatf("%s%0d.busy", tag, i), tx_busy, e.busy);
      chk($sformatf("%s%0d.tvalid", tag, i), tvalid_to_router, e.busy & e.vld);
      exp_rdy = e.busy ? (NC'(e.rdy) << e.g) : '0;
      chk($sformatf("%s%0d.tready", tag, i), tready_to_trans, exp_rdy);
      if (e.busy) chk($sformatf("%s%0d.grant", tag, i), tx_grant_ch, e.g);
      if (!e.busy || e.vld) begin
        chk($sformatf("%s%0d.tlast", tag, i), tlast_to_router, e.busy & e.last);
        chk($sformatf("%s%0d.tdata", tag, i), tdata_to_router, e.busy ? data_of(e.g, e.b) : '0);
        chk($sformatf("%s%0d.tkeep", tag, i), tkeep_to_router, e.busy ? keep_of(e.g) : '0);
        chk($sformatf("%s%0d.tuser", tag, i), tuser_to_router, e.busy ? user_of(e.g) : '0);
      end
      ch_hs = tvalid_from & tready_to_trans;
      if (tvalid_to_router && tready_from_router) hs++;
      @(posedge user_clk);
      #1;
      for (int c = 0; c < NC; c++) begin
        if (ch_hs[c]) begin
          s_beat[c]++;
          if (s_beat[c] == s_len[c]) begin
            s_beat[c] = 0;
            s_pkts[c]--;
          end
        end
      end
    end
    chk({tag, ".beats"}, hs, exp_hs);
    tbl.delete();
  endtask

  initial begin
    int ord5[5];
    int ord6[6];
`ifdef TX_ARB_PRIO_EN
    ord5 = '{0, 0, 1, 2, 3};
    ord6 = '{0, 0, 0, 1, 1, 1};
`else
    ord5 = '{0, 1, 2, 3, 0};
    ord6 = '{0, 1, 0, 1, 0, 1};
`endif
    clear_srcs();
    do_reset("rst0");

    // ch0 and ch2, 3-beat packets: ch0 first, one idle ARB cycle, then ch2
    load(0, 3, 1);
    load(2, 3, 1);
    cy(0, 1, 0, 0, 0, 0, 0);
    cy(0, 1, 1, 1, 0, 0, 0);
    cy(0, 1, 1, 1, 0, 0, 1);
    cy(0, 1, 1, 1, 1, 0, 2);
    cy(0, 1, 0, 0, 0, 0, 0);
    cy(0, 1, 1, 1, 0, 2, 0);
    cy(0, 1, 1, 1, 0, 2, 1);
    cy(0, 1, 1, 1, 1, 2, 2);
    cy(0, 1, 0, 0, 0, 0, 0);
    run_tbl("s1_", 6);

    // all channels busy, 2-beat packets, ch0 has a second packet
    do_reset("rst1");
    load(0, 2, 2);
    load(1, 2, 1);
    load(2, 2, 1);
    load(3, 2, 1);
    for (int k = 0; k < 5; k++) begin
      cy(0, 1, 0, 0, 0, 0, 0);
      cy(0, 1, 1, 1, 0, ord5[k], 0);
      cy(0, 1, 1, 1, 1, ord5[k], 1);
    end
    cy(0, 1, 0, 0, 0, 0, 0);
    run_tbl("s2_", 10);

    // ch1 alone, router ready toggling
    load(1, 4, 1);
    cy(0, 1, 0, 0, 0, 0, 0);
    cy(0, 1, 1, 1, 0, 1, 0);
    cy(0, 0, 1, 1, 0, 1, 1);
    cy(0, 1, 1, 1, 0, 1, 1);
    cy(0, 0, 1, 1, 0, 1, 2);
    cy(0, 1, 1, 1, 0, 1, 2);
    cy(0, 0, 1, 1, 1, 1, 3);
    cy(0, 1, 1, 1, 1, 1, 3);
    cy(0, 1, 0, 0, 0, 0, 0);
    run_tbl("s3_", 4);

    // ch3 bubbles two cycles while ch0 waits for the packet to end
    load(3, 4, 1);
    load(0, 2, 1);
    cy(4'b0001, 1, 0, 0, 0, 0, 0);
    cy(4'b0000, 1, 1, 1, 0, 3, 0);
    cy(4'b1000, 1, 1, 0, 0, 3, 1);
    cy(4'b1000, 1, 1, 0, 0, 3, 1);
    cy(4'b0000, 1, 1, 1, 0, 3, 1);
    cy(4'b0000, 1, 1, 1, 0, 3, 2);
    cy(4'b0000, 1, 1, 1, 1, 3, 3);
    cy(4'b0000, 1, 0, 0, 0, 0, 0);
    cy(4'b0000, 1, 1, 1, 0, 0, 0);
    cy(4'b0000, 1, 1, 1, 1, 0, 1);
    cy(4'b0000, 1, 0, 0, 0, 0, 0);
    run_tbl("s4_", 6);

    // reset during beat 2 of a 4-beat ch2 packet, then ch0 must win over ch1
    load(2, 4, 1);
    cy(0, 1, 0, 0, 0, 0, 0);
    cy(0, 1, 1, 1, 0, 2, 0);
    run_tbl("s5a_", 1);
    do_reset("s5rst");
    load(0, 1, 1);
    load(1, 1, 1);
    cy(0, 1, 0, 0, 0, 0, 0);
    cy(0, 1, 1, 1, 1, 0, 0);
    cy(0, 1, 0, 0, 0, 0, 0);
    cy(0, 1, 1, 1, 1, 1, 0);
    cy(0, 1, 0, 0, 0, 0, 0);
    run_tbl("s5b_", 2);

    // ch0 and ch1 contend with single-beat packets
    load(0, 1, 3);
    load(1, 1, 3);
    for (int k = 0; k < 6; k++) begin
      cy(0, 1, 0, 0, 0, 0, 0);
      cy(0, 1, 1, 1, 1, ord6[k], 0);
    end
    cy(0, 1, 0, 0, 0, 0, 0);
    run_tbl("s6_", 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_pkt_arbiter.md
TX_PKT_ARBITER -- requirements
Module: tx_pkt_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the stream width in bytes.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning the number of transport channels arbitrated (2..8).
REQ-003 SHALL have port user_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port axi_str_tdata_from_trans, input, NUM_CH*DATA_WIDTH*8 bits: per-channel data, with channel i at slice i.
REQ-006 SHALL have port axi_str_tkeep_from_trans, input, NUM_CH*DATA_WIDTH bits: per-channel byte enables.
REQ-007 SHALL have port axi_str_tuser_from_trans, input, NUM_CH*4 bits: per-channel sideband.
REQ-008 SHALL have ports axi_str_tvalid_from_trans and axi_str_tlast_from_trans, input, NUM_CH bits each: per-channel valid and last.
REQ-009 SHALL have port axi_str_tready_to_trans, output, NUM_CH bits: per-channel ready.
REQ-010 SHALL have ports axi_str_tdata_to_router (DATA_WIDTH*8), axi_str_tkeep_to_router (DATA_WIDTH), axi_str_tuser_to_router (4), axi_str_tvalid_to_router (1) and axi_str_tlast_to_router (1), all outputs: the merged stream.
REQ-011 SHALL have port axi_str_tready_from_router, input, 1 bit: router backpressure.
REQ-012 SHALL have port tx_grant_ch, output, $clog2(NUM_CH) bits: index of the granted channel.
REQ-013 SHALL have port tx_busy, output, 1 bit: high while a packet is owned.

Function
REQ-014 SHALL implement an FSM with two states: ARB and XFER.
REQ-015 In ARB, all outputs to the router and all tready_to_trans bits SHALL be 0.
REQ-016 In ARB, any asserted tvalid SHALL register a grant chosen by round-robin starting at last_grant+1 mod NUM_CH, and the FSM SHALL move to XFER on the next cycle.
REQ-017 Arbitration latency SHALL be exactly 1 cycle from the first valid in ARB to the first possible output beat.
REQ-018 In XFER, the router outputs SHALL combinationally mirror the granted channel's tdata, tkeep, tuser, tvalid and tlast.
REQ-019 In XFER, tready_to_trans[grant] SHALL equal tready_from_router, and all other tready bits SHALL be 0.
REQ-020 The grant SHALL be held for the whole packet; no preemption is allowed mid-packet.
REQ-021 A beat with tvalid, tready and tlast all set in XFER SHALL set last_grant to grant and return the FSM to ARB; the next grant needs a fresh ARB cycle (1 idle cycle between packets).
REQ-022 When tvalid drops mid-packet (a bubble), the FSM SHALL stay in XFER, output tvalid SHALL be 0, and the grant SHALL hold.
REQ-023 A single-beat packet (tlast on the first beat) SHALL be legal and SHALL return the FSM to ARB after that beat.
REQ-024 When only one channel requests, it SHALL be granted regardless of last_grant.
REQ-025 Round-robin order SHALL wrap from NUM_CH-1 to 0.
REQ-026 tx_busy SHALL be 1 exactly when the state is XFER; tx_grant_ch SHALL show the registered grant.
REQ-027 axi_str_tuser_to_router SHALL pass the granted channel's tuser unmodified.

Reset
REQ-028 While reset_n=0 at a clock edge, the state SHALL become ARB, grant SHALL become 0, and last_grant SHALL become NUM_CH-1, so channel 0 wins first.
REQ-029 During and after reset, all outputs SHALL be 0, including tx_busy and every tready bit.
REQ-030 Reset mid-packet SHALL abandon the packet with no further beats forwarded; upstream channels are responsible for flushing it.

Configuration
REQ-031 With macro TX_ARB_PRIO_EN defined, channel 0 SHALL have strict priority in ARB: if its tvalid is set it wins, and round-robin applies among channels 1..NUM_CH-1.
REQ-032 With TX_ARB_PRIO_EN defined, channel 0 SHALL still not preempt a packet in progress.
REQ-033 Without TX_ARB_PRIO_EN, pure round-robin SHALL apply over all channels.

Structure
REQ-034 A shared package SHALL hold the state encoding (ARB=2'b01, XFER=2'b10) and the 4-bit tuser width constant.
REQ-035 The round-robin selector SHALL be one sub-module, rr_select, with inputs req[NUM_CH] and last[$clog2(NUM_CH)] and outputs gnt_idx and gnt_vld; it is combinational and instantiated once.

Verification
REQ-036 Ch0 and ch2 valid after reset, 3-beat packets each -> ch0 is granted first, with 3 beats out and tlast on beat 3; then ch2 is granted, with exactly 1 idle cycle between the packets.
REQ-037 All 4 channels continuously valid, 2-beat packets -> grant order 0,1,2,3,0; tx_grant_ch matches each packet.
REQ-038 Ch1 packet with router tready toggling 1,0,1,0 -> no beat is lost or duplicated, and tready_to_trans[1] tracks tready_from_router.
REQ-039 Ch3 deasserts tvalid for 2 cycles mid-packet while ch0 is valid -> the grant stays on 3 and ch0 waits for ch3's tlast.
REQ-040 reset_n driven low for 1 cycle during beat 2 of a 4-beat packet -> all outputs are 0 the next cycle, the state is ARB, and the next grant goes to channel 0.
REQ-041 With TX_ARB_PRIO_EN defined, ch0 and ch1 contend repeatedly -> ch0 wins every ARB; without the macro -> they alternate 0,1,0,1.
